// File: rtl/mult_feeder.sv
// mult_feeder: buffers operand pairs in a 2-entry FIFO and feeds them, one
// at a time, to an external shift-and-add multiplier, then presents the
// product with a valid/ready handshake.
// Optional build macro: MULT_FEEDER_SIGNED_EN (two's complement operands;
// the multiplier sees magnitudes and the product sign is restored here).
module mult_feeder (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        mul_start,
   input  logic        mul_ready,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_p
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;

   // Operand FIFO storage and bookkeeping
   logic [31:0] fifo_a_q [2];
   logic [31:0] fifo_b_q [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;

   logic [31:0] mul_a_q, mul_a_d;
   logic [31:0] mul_b_q, mul_b_d;
   logic [63:0] out_p_q, out_p_d;
   logic        out_valid_q, out_valid_d;

   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        capture;
   logic [31:0] head_a;
   logic [31:0] head_b;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [63:0] result;

   // Full/empty come from the registered count only, so a write into a full
   // FIFO is refused even if a pop happens on the same edge.
   assign fifo_full  = (count_q == 2'd2);
   assign fifo_empty = (count_q == 2'd0);
   assign in_ready   = !fifo_full;
   assign push       = in_valid && !fifo_full;
   assign pop        = (state_q == S_IDLE) && !fifo_empty && mul_ready;
   assign capture    = (state_q == S_WAIT_DONE) && mul_ready;
   assign head_a     = fifo_a_q[rd_ptr_q];
   assign head_b     = fifo_b_q[rd_ptr_q];

`ifdef MULT_FEEDER_SIGNED_EN
   logic sign_q, sign_d;

   // Magnitudes go to the multiplier; 0x80000000 negates to itself, which is
   // the correct unsigned magnitude.
   always_comb begin
      op_a   = head_a[31] ? (~head_a + 32'd1) : head_a;
      op_b   = head_b[31] ? (~head_b + 32'd1) : head_b;
      sign_d = pop ? (head_a[31] ^ head_b[31]) : sign_q;
      result = sign_q ? (~mul_p + 64'd1) : mul_p;
   end

   // Product sign, latched with the operands at issue time
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sign_q <= 1'b0;
      else        sign_q <= sign_d;
   end
`else
   // Unsigned build: operands and product pass straight through
   always_comb begin
      op_a   = head_a;
      op_b   = head_b;
      result = mul_p;
   end
`endif

   // Next-state and datapath-update logic
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      out_p_d     = out_p_q;
      out_valid_d = out_valid_q;

      if (push) wr_ptr_d = !wr_ptr_q;
      if (pop) begin
         rd_ptr_d = !rd_ptr_q;
         mul_a_d  = op_a;
         mul_b_d  = op_b;
      end

      case (state_q)
         S_IDLE:      if (pop) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!mul_ready) state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (capture) begin
               state_d     = S_HOLD;
               out_p_d     = result;
               out_valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default:     state_d = S_IDLE;
      endcase
   end

   // State, pointer and output registers; reset discards any queued work
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         mul_a_q     <= 32'd0;
         mul_b_q     <= 32'd0;
         out_p_q     <= 64'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         out_p_q     <= out_p_d;
         out_valid_q <= out_valid_d;
      end
   end

   // FIFO entry write; contents are don't-care while the entry is unused
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            fifo_a_q[i] <= 32'd0;
            fifo_b_q[i] <= 32'd0;
         end
      end else if (push) begin
         fifo_a_q[wr_ptr_q] <= in_a;
         fifo_b_q[wr_ptr_q] <= in_b;
      end
   end

   assign mul_start = (state_q == S_ISSUE);
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_p     = out_p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_feeder.sv
// tb_mult_feeder: randomized scoreboard bench for mult_feeder with a
// behavioural shift-and-add multiplier of random busy time.
module tb_mult_feeder;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        mul_start;
   logic        mul_ready;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_p;

   mult_feeder dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_start (mul_start),
      .mul_ready (mul_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } txn_t;

   txn_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_xfer = 0;

   // bench-side controls
   logic stall = 1'b0;      // multiplier reports busy while idle
   logic force_bp = 1'b0;   // hold out_ready low
   logic long_mode = 1'b0;  // long multiplier busy time
   int   phase = 0;         // multiplier model: 0 idle,1 started,2 busy,3 done

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference product from the operand pair as presented upstream
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_FEEDER_SIGNED_EN
      logic signed [63:0] sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
`else
      return {32'd0, a} * {32'd0, b};
`endif
   endfunction

   // Called at a negedge; returns at the negedge after the pair is accepted
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int w;
      txn_t t;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      w = 0;
      while (!in_ready && w < 300) begin
         @(negedge clock);
         w++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
      end else begin
         t.a = a;
         t.b = b;
         t.p = ref_prod(a, b);
         exp_q.push_back(t);
         @(negedge clock);
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && phase == 0 && !out_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'(($urandom_range(0, 20)));
         default: return $urandom;
      endcase
   endfunction

   // Downstream ready: random unless backpressure is forced
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #3;
         out_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Behavioural multiplier: drops ready after the start edge, stays busy a
   // random number of cycles, then raises ready with the product.
   initial begin
      logic [31:0] a_c, b_c;
      int cnt;
      mul_ready = 1'b1;
      mul_p = 64'd0;
      a_c = 32'd0;
      b_c = 32'd0;
      cnt = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            phase = 0;
            mul_ready = 1'b1;
         end else begin
            case (phase)
               0: begin
                  mul_ready = !stall;
                  if (mul_start) begin
                     a_c = mul_a;
                     b_c = mul_b;
                     phase = 1;
                  end
               end
               1: begin
                  mul_ready = 1'b0;
                  cnt = long_mode ? 6 : $urandom_range(1, 4);
                  phase = 2;
               end
               2: begin
                  chk("mul_a_stable", 64'(mul_a), 64'(a_c));
                  chk("mul_b_stable", 64'(mul_b), 64'(b_c));
                  chk("no_restart_busy", 64'(mul_start), 64'd0);
                  chk("no_early_valid", 64'(out_valid), 64'd0);
                  cnt--;
                  if (cnt == 0) begin
                     mul_p = {32'd0, a_c} * {32'd0, b_c};
                     mul_ready = 1'b1;
                     phase = 3;
                  end
               end
               default: begin
                  chk("valid_latency", 64'(out_valid), 64'd1);
                  mul_ready = !stall;
                  phase = 0;
               end
            endcase
         end
      end
   end

   // Output monitor: pops the scoreboard on each transfer, checks hold stability
   initial begin
      logic        held;
      logic [63:0] held_val;
      txn_t t;
      held = 1'b0;
      held_val = 64'd0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_stable", out_p, held_val);
            end
            if (out_valid) begin
               chk("no_start_in_hold", 64'(mul_start), 64'd0);
               if (out_ready) begin
                  held = 1'b0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_output", 64'(out_valid), 64'd0);
                  end else begin
                     t = exp_q.pop_front();
                     n_xfer++;
                     $display("xfer %0d: %h * %h -> %h (expect %h)", n_xfer, t.a, t.b, out_p, t.p);
                     chk("product", out_p, t.p);
                  end
               end else begin
                  held = 1'b1;
                  held_val = out_p;
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      bit seen;
      reset = 1'b0;
      in_valid = 1'b0;
      in_a = 32'd0;
      in_b = 32'd0;

      // reset state
      repeat (3) @(negedge clock);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mul_start", 64'(mul_start), 64'd0);
      chk("rst_out_p", out_p, 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // directed corner operands
      send(32'd3, 32'd5);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(32'hFFFF_FFFD, 32'd5);
      send(32'h8000_0000, 32'hFFFF_FFFF);
      in_valid = 1'b0;
      wait_idle();

      // back-to-back with multiplier reporting busy: FIFO fills at two
      @(posedge clock);
      #1 stall = 1'b1;
      @(negedge clock);
      send(32'd11, 32'd13);
      send(32'd17, 32'd19);
      in_valid = 1'b1;
      in_a = 32'd23;
      in_b = 32'd29;
      for (int i = 0; i < 3; i++) begin
         chk("full_in_ready", 64'(in_ready), 64'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1 stall = 1'b0;
      @(negedge clock);
      send(32'd23, 32'd29);
      in_valid = 1'b0;
      wait_idle();

      // backpressure: result held for 10 cycles, no new start meanwhile
      @(posedge clock);
      #1 force_bp = 1'b1;
      @(negedge clock);
      send(32'h1234_5678, 32'h9ABC_DEF0);
      send(32'd7, 32'd9);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else @(negedge clock);
      end
      chk("bp_valid_seen", 64'(seen), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_no_start", 64'(mul_start), 64'd0);
         @(negedge clock);
      end
      @(posedge clock);
      #1 force_bp = 1'b0;
      wait_idle();

      // reset while waiting for the multiplier to finish
      @(posedge clock);
      #1 long_mode = 1'b1;
      @(negedge clock);
      send(32'd100, 32'd200);
      send(32'd300, 32'd400);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clock);
         #1;
         if (phase == 2) seen = 1'b1;
      end
      chk("reach_wait_done", 64'(seen), 64'd1);
      #1 reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_mul_start", 64'(mul_start), 64'd0);
      chk("mid_rst_out_p", out_p, 64'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      long_mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("post_rst_quiet", 64'(out_valid | mul_start), 64'd0);
         chk("post_rst_empty", 64'(in_ready), 64'd1);
      end
      send(32'd2, 32'd7);
      in_valid = 1'b0;
      wait_idle();

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clock);
         send(rand_op(), rand_op());
      end
      in_valid = 1'b0;
      wait_idle();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
